// File: rtl/slip_pkg.sv
// Shared SLIP framing codes and deframer state encoding.
package slip_pkg;

    localparam logic [7:0] SLIP_END     = 8'hC0;
    localparam logic [7:0] SLIP_ESC     = 8'hDB;
    localparam logic [7:0] SLIP_ESC_END = 8'hDC;
    localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        DATA   = 2'd1,
        ESCAPE = 2'd2,
        DROP   = 2'd3
    } slip_state_e;

endpackage

// File: rtl/uart_slip_deframer.sv
// SLIP deframer: decodes a UART byte stream into big-endian words of WORD_BYTES
// bytes, with a one-word staging register so the final word of a frame carries tlast.
module uart_slip_deframer
    import slip_pkg::*;
#(
    parameter int WORD_BYTES = 2
) (
    input  logic                    clk,
    input  logic                    arstn,
    input  logic [7:0]              s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [8*WORD_BYTES-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    esc_error,
    output logic                    len_error,
    output logic [15:0]             frame_count,
    output slip_state_e             state_dbg
);

    // Both streams use valid/ready: a beat transfers on a rising edge where
    // tvalid and tready are both high; tvalid/tdata/tlast hold until then.

    localparam int DATA_W = 8 * WORD_BYTES;
    localparam int CNT_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_BYTES - 1);

    slip_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] part_q, part_d;
    logic [DATA_W-1:0] stg_q, stg_d;
    logic              stg_vld_q, stg_vld_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_vld_q, out_vld_d;
    logic              out_last_q, out_last_d;
    logic              esc_err_q, esc_err_d;
    logic              len_err_q, len_err_d;
    logic [15:0]       fcnt_q, fcnt_d;

    logic              byte_fire;
    logic              pay_en;
    logic [7:0]        pay_byte;
    logic [DATA_W-1:0] word;

    // The output register is either empty or draining whenever a byte is taken,
    // so any load triggered by that byte never overwrites an unaccepted word.
    assign s_axis_tready = !(out_vld_q && !m_axis_tready);
    assign byte_fire     = s_axis_tvalid && s_axis_tready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        part_d     = part_q;
        stg_d      = stg_q;
        stg_vld_d  = stg_vld_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        out_vld_d  = out_vld_q && !m_axis_tready;
        esc_err_d  = 1'b0;
        len_err_d  = 1'b0;
        fcnt_d     = fcnt_q;
        pay_en     = 1'b0;
        pay_byte   = s_axis_tdata;
        word       = (part_q << 8) | DATA_W'(pay_byte);

        if (byte_fire) begin
            case (state_q)
                HUNT: if (s_axis_tdata == SLIP_END) state_d = DATA;
                DATA: begin
                    if (s_axis_tdata == SLIP_ESC) begin
                        state_d = ESCAPE;
                    end else if (s_axis_tdata == SLIP_END) begin
                        if (cnt_q != '0) begin
                            len_err_d = 1'b1;
                            cnt_d     = '0;
                        end
                        if (stg_vld_q) begin
                            out_data_d = stg_q;
                            out_last_d = 1'b1;
                            out_vld_d  = 1'b1;
                            stg_vld_d  = 1'b0;
                            fcnt_d     = fcnt_q + 16'd1;
                        end
                    end else begin
                        pay_en = 1'b1;
                    end
                end
                ESCAPE: begin
                    if (s_axis_tdata == SLIP_ESC_END) begin
                        pay_en   = 1'b1;
                        pay_byte = SLIP_END;
                        state_d  = DATA;
                    end else if (s_axis_tdata == SLIP_ESC_ESC) begin
                        pay_en   = 1'b1;
                        pay_byte = SLIP_ESC;
                        state_d  = DATA;
                    end else begin
                        esc_err_d = 1'b1;
                        cnt_d     = '0;
                        stg_vld_d = 1'b0;
                        state_d   = DROP;
                    end
                end
                DROP: if (s_axis_tdata == SLIP_END) state_d = DATA;
                default: state_d = HUNT;
            endcase
        end

        if (pay_en) begin
            word   = (part_q << 8) | DATA_W'(pay_byte);
            part_d = word;
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                // A full staging slot means its word is not the frame's last.
                if (stg_vld_q) begin
                    out_data_d = stg_q;
                    out_last_d = 1'b0;
                    out_vld_d  = 1'b1;
                end
                stg_d     = word;
                stg_vld_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q    <= HUNT;
            cnt_q      <= '0;
            part_q     <= '0;
            stg_q      <= '0;
            stg_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            esc_err_q  <= 1'b0;
            len_err_q  <= 1'b0;
            fcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            part_q     <= part_d;
            stg_q      <= stg_d;
            stg_vld_q  <= stg_vld_d;
            out_data_q <= out_data_d;
            out_vld_q  <= out_vld_d;
            out_last_q <= out_last_d;
            esc_err_q  <= esc_err_d;
            len_err_q  <= len_err_d;
            fcnt_q     <= fcnt_d;
        end
    end

    assign m_axis_tdata  = out_data_q;
    assign m_axis_tvalid = out_vld_q;
    assign m_axis_tlast  = out_last_q;
    assign esc_error     = esc_err_q;
    assign len_error     = len_err_q;
    assign frame_count   = fcnt_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_uart_slip_deframer.sv
// Directed bench for uart_slip_deframer (WORD_BYTES=2) with an output scoreboard.
module tb_uart_slip_deframer;
    import slip_pkg::*;

    localparam int WB = 2;
    localparam int DW = 8 * WB;

    logic          clk = 1'b0;
    logic          arstn = 1'b0;
    logic [7:0]    s_tdata = 8'h00;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          m_tlast;
    logic          esc_error;
    logic          len_error;
    logic [15:0]   frame_count;
    slip_state_e   state_dbg;

    int errors = 0;
    int checks = 0;
    int esc_pulses = 0;
    int len_pulses = 0;

    // Expected beats as {tlast, tdata}.
    logic [DW:0] exp_q[$];

    uart_slip_deframer #(.WORD_BYTES(WB)) dut (
        .clk          (clk),
        .arstn        (arstn),
        .s_axis_tdata (s_tdata),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .m_axis_tdata (m_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tlast (m_tlast),
        .esc_error    (esc_error),
        .len_error    (len_error),
        .frame_count  (frame_count),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor on the falling edge: a beat seen valid&ready here transfers at the next rise.
    logic          prev_stall = 1'b0;
    logic [DW:0]   prev_beat = '0;
    always @(negedge clk) begin
        if (arstn) begin
            if (esc_error) esc_pulses++;
            if (len_error) len_pulses++;
            if (prev_stall) begin
                check("hold_valid", 32'(m_tvalid), 32'd1);
                check("hold_beat", 32'({m_tlast, m_tdata}), 32'(prev_beat));
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'({m_tlast, m_tdata}), 32'h0);
                end else begin
                    logic [DW:0] e;
                    e = exp_q.pop_front();
                    check("beat", 32'({m_tlast, m_tdata}), 32'(e));
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_beat  = {m_tlast, m_tdata};
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        s_tvalid = 1'b1;
        s_tdata  = b;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!s_tready && t < 300);
        if (!s_tready) check("send_timeout", 32'(t), 32'd0);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
    endtask

    task automatic send_seq(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i]);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || m_tvalid) && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tdata", 32'(m_tdata), 32'd0);
        check("rst_tlast", 32'(m_tlast), 32'd0);
        check("rst_fcnt", 32'(frame_count), 32'd0);
        check("rst_errs", 32'({esc_error, len_error}), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(HUNT));
        arstn = 1'b1;
        @(posedge clk);
        #1;
        check("idle_s_tready", 32'(s_tready), 32'd1);

        // Bytes ahead of the first END are discarded.
        send_seq('{8'h11, 8'h22});
        check("hunt_state", 32'(state_dbg), 32'(HUNT));

        // Two-word frame.
        exp_q.push_back({1'b0, 16'h1234});
        exp_q.push_back({1'b1, 16'h5678});
        send_seq('{8'hC0, 8'h12, 8'h34, 8'h56, 8'h78, 8'hC0});
        drain();
        check("fcnt_two_word", 32'(frame_count), 32'd1);

        // Escaped END and ESC payload bytes.
        exp_q.push_back({1'b1, 16'hC0DB});
        send_seq('{8'hC0, 8'hDB, 8'hDC, 8'hDB, 8'hDD, 8'hC0});
        drain();
        check("fcnt_escape", 32'(frame_count), 32'd2);

        // Frame ends mid-word.
        exp_q.push_back({1'b1, 16'h1234});
        send_seq('{8'hC0, 8'h12, 8'h34, 8'h56, 8'hC0});
        drain();
        check("len_pulses", 32'(len_pulses), 32'd1);
        check("fcnt_len", 32'(frame_count), 32'd3);

        // Invalid escape aborts the frame; the next frame survives.
        send_seq('{8'hC0, 8'h12, 8'hDB, 8'h99});
        check("drop_state", 32'(state_dbg), 32'(DROP));
        exp_q.push_back({1'b1, 16'hABCD});
        send_seq('{8'h34, 8'hC0, 8'hAB, 8'hCD, 8'hC0});
        drain();
        check("esc_pulses", 32'(esc_pulses), 32'd1);
        check("fcnt_esc", 32'(frame_count), 32'd4);

        // Empty frames are ignored.
        send_seq('{8'hC0, 8'hC0});
        drain();
        check("fcnt_empty", 32'(frame_count), 32'd4);
        check("len_after_empty", 32'(len_pulses), 32'd1);

        // Output stalled for 20 cycles mid-stream.
        m_tready = 1'b0;
        exp_q.push_back({1'b0, 16'h1234});
        exp_q.push_back({1'b1, 16'h5678});
        fork
            send_seq('{8'hC0, 8'h12, 8'h34, 8'h56, 8'h78, 8'hC0});
            begin
                repeat (20) @(posedge clk);
                #1;
                check("stall_s_tready", 32'(s_tready), 32'd0);
                check("stall_tvalid", 32'(m_tvalid), 32'd1);
                check("stall_tdata", 32'(m_tdata), 32'h1234);
                m_tready = 1'b1;
            end
        join
        drain();
        check("fcnt_stall", 32'(frame_count), 32'd5);

        // Reset mid-frame abandons it.
        send_seq('{8'hC0, 8'h12});
        arstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_state", 32'(state_dbg), 32'(HUNT));
        check("mid_rst_fcnt", 32'(frame_count), 32'd0);
        arstn = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back({1'b1, 16'hAABB});
        send_seq('{8'hC0, 8'hAA, 8'hBB, 8'hC0});
        drain();
        check("fcnt_after_rst", 32'(frame_count), 32'd1);
        check("esc_total", 32'(esc_pulses), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
